ov7670_stream_gen: RTL and testbench

- Synthesizable OV7670 DVP video source: drives `vsync`/`href`/8-bit data with OV7670 VGA RGB565 frame timing and generates selectable test patterns.
- It is the transmit end of the camera pixel interface that `ov7670_capture` receives.
- Replaces the physical camera for capture-path simulation and for on-board bring-up of the frame-buffer/core/VGA chain.
- Outputs change only on rising `clk25` edges; the consumer samples on the following rising edge.

---
 rtl/ov7670_stream_pkg.sv | 52 +++++
 rtl/ov7670_stream_gen_if.sv | 9 +
 rtl/ov7670_pattern_pixel.sv | 31 +++
 rtl/ov7670_stream_gen.sv | 165 ++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_stream_pkg.sv
// Shared types and constants for the OV7670 DVP test-pattern source:
// FSM states, pattern ids, RGB565 bar colours and VGA default timing.
package ov7670_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_RAMP,
    PAT_CHECKER,
    PAT_MOVING
  } pattern_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // OV7670 VGA RGB565 timing; H_BLANK is 144 tP at two byte clocks per tP
  localparam int OV_WIDTH   = 640;
  localparam int OV_HEIGHT  = 480;
  localparam int OV_H_BLANK = 288;
  localparam int OV_V_SYNC  = 3;
  localparam int OV_V_BP    = 17;
  localparam int OV_V_FP    = 10;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// DVP video bus between the pattern source (master) and a capture block (slave).
interface ov7670_stream_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] dout;

  modport master (output vsync, output href, output dout);
  modport slave  (input vsync, input href, input dout);
endinterface

// File: rtl/ov7670_pattern_pixel.sv
// Combinational test-pattern generator: pixel coordinate, pattern id and
// frame counter in, one RGB565 word out.
module ov7670_pattern_pixel
  import ov7670_stream_pkg::*;
#(
  parameter int WIDTH = OV_WIDTH
) (
  input  logic [15:0] x_i,
  input  logic [4:0]  y_i,
  input  pattern_e    pattern_i,
  input  logic [4:0]  frame_cnt_i,
  output logic [15:0] pixel_o
);

  localparam int BAR_W = WIDTH / 8;

  logic [15:0] bar_idx;

  always_comb begin
    bar_idx = x_i / 16'(BAR_W);
    pixel_o = BAR_BLACK;
    case (pattern_i)
      PAT_BARS:    pixel_o = (bar_idx > 16'd7) ? BAR_BLACK : bar_colour(bar_idx[2:0]);
      PAT_RAMP:    pixel_o = {x_i[4:0], x_i[5:0], x_i[4:0]};
      PAT_CHECKER: pixel_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
      PAT_MOVING:  pixel_o = {y_i, x_i[5:0], frame_cnt_i};
      default:     pixel_o = BAR_BLACK;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 VGA RGB565 DVP source with selectable test patterns.
// Define OV7670_STREAM_GEN_CKSUM_EN to build the per-frame byte checksum.
module ov7670_stream_gen
  import ov7670_stream_pkg::*;
#(
  parameter int WIDTH   = OV_WIDTH,
  parameter int HEIGHT  = OV_HEIGHT,
  parameter int H_BLANK = OV_H_BLANK,
  parameter int V_SYNC  = OV_V_SYNC,
  parameter int V_BP    = OV_V_BP,
  parameter int V_FP    = OV_V_FP
) (
  input  logic                       clk25,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 pattern_sel,
  ov7670_stream_gen_if.master        vid,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic [15:0]                frame_sum
);

  localparam int H_TOTAL = 2 * WIDTH + H_BLANK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_MAX_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX_B = (HEIGHT > V_FP) ? HEIGHT : V_FP;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HREF_END = HW'(2 * WIDTH);

  state_e      state_q;
  pattern_e    pat_q;
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic        vsync_q;
  logic        href_q;
  logic [7:0]  dout_q;
  logic        busy_q;
  logic        frame_done_q;
  logic [7:0]  frame_cnt_q;

  logic [VW-1:0] v_last_line;
  logic          h_last;
  logic          v_last;
  logic          href_d;
  logic [7:0]    dout_d;
  logic [15:0]   x_pix;
  logic [4:0]    y_pix;
  logic [15:0]   pixel;

  always_comb begin
    v_last_line = '0;
    case (state_q)
      ST_VSYNC:  v_last_line = VW'(V_SYNC - 1);
      ST_VBP:    v_last_line = VW'(V_BP - 1);
      ST_ACTIVE: v_last_line = VW'(HEIGHT - 1);
      ST_VFP:    v_last_line = VW'(V_FP - 1);
      default:   v_last_line = '0;
    endcase
  end

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == v_last_line);
  assign x_pix  = 16'(hcnt_q >> 1);
  assign y_pix  = 5'(vcnt_q);
  assign href_d = (state_q == ST_ACTIVE) && (hcnt_q < HREF_END);
  // High byte of each RGB565 word goes out on the even byte clock
  assign dout_d = href_d ? (hcnt_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;

  ov7670_pattern_pixel #(.WIDTH(WIDTH)) u_pixel (
    .x_i         (x_pix),
    .y_i         (y_pix),
    .pattern_i   (pat_q),
    .frame_cnt_i (frame_cnt_q[4:0]),
    .pixel_o     (pixel)
  );

  // Outputs are decoded from the current state, so the whole bus trails the
  // state register by one clock and vsync/href/dout stay mutually aligned.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pat_q        <= PAT_BARS;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      dout_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      vsync_q      <= (state_q == ST_VSYNC);
      href_q       <= href_d;
      dout_q       <= dout_d;
      busy_q       <= (state_q != ST_IDLE);
      frame_done_q <= (state_q == ST_VFP) && h_last && v_last;
      frame_cnt_q  <= frame_cnt_q + {7'd0, frame_done_q};

      if (state_q == ST_IDLE) begin
        hcnt_q <= '0;
        vcnt_q <= '0;
        if (en) begin
          state_q <= ST_VSYNC;
          pat_q   <= pattern_e'(pattern_sel);
        end
      end else if (!h_last) begin
        hcnt_q <= hcnt_q + 1'b1;
      end else begin
        hcnt_q <= '0;
        if (!v_last) begin
          vcnt_q <= vcnt_q + 1'b1;
        end else begin
          vcnt_q <= '0;
          case (state_q)
            ST_VSYNC:  state_q <= ST_VBP;
            ST_VBP:    state_q <= ST_ACTIVE;
            ST_ACTIVE: state_q <= ST_VFP;
            default: begin
              if (en) begin
                state_q <= ST_VSYNC;
                pat_q   <= pattern_e'(pattern_sel);
              end else begin
                state_q <= ST_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  assign vid.vsync  = vsync_q;
  assign vid.href   = href_q;
  assign vid.dout   = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef OV7670_STREAM_GEN_CKSUM_EN
  logic [15:0] sum_q;
  logic [15:0] frame_sum_q;

  // Clearing on frame_done lines up with the output-side VSYNC entry
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      sum_q       <= 16'h0000;
      frame_sum_q <= 16'h0000;
    end else if (frame_done_q) begin
      frame_sum_q <= sum_q;
      sum_q       <= 16'h0000;
    end else if (href_q) begin
      sum_q <= sum_q + {8'h00, dout_q};
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen at reduced timing (20-clock lines, 140-clock frames).
module tb_ov7670_stream_gen;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int HT    = 2 * W + HB;
  localparam int FRAME = (VS + VB + H + VF) * HT;
  localparam int ACT0  = (VS + VB) * HT;

`ifdef OV7670_STREAM_GEN_CKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif

  logic        clk25 = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern_sel;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic [15:0] frame_sum;

  int vectors    = 0;
  int miscompares = 0;

  ov7670_stream_gen_if vid();

  ov7670_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VB), .V_FP(VF)
  ) dut (
    .clk25       (clk25),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .vid         (vid),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .frame_sum   (frame_sum)
  );

  always #5 clk25 = ~clk25;

  function automatic logic [15:0] model_pix(input logic [1:0] pat, input int x, input int y,
                                            input logic [7:0] fc);
    logic [15:0] xv;
    logic [15:0] yv;
    logic [15:0] p;
    xv = 16'(x);
    yv = 16'(y);
    case (pat)
      2'd0: begin
        case (x)
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      2'd1:    p = {xv[4:0], xv[5:0], xv[4:0]};
      2'd2:    p = (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
      default: p = {yv[4:0], xv[5:0], fc[4:0]};
    endcase
    return p;
  endfunction

  // Starts a frame from IDLE; returns at the first sample with vsync high.
  task automatic start_frame(input logic [1:0] sel, input bit hold_en);
    pattern_sel = sel;
    en = 1'b1;
    @(negedge clk25);
    vectors++;
    if (vid.vsync !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latency vsync=%b busy=%b want 0 0", vid.vsync, busy);
    end
    pattern_sel = sel ^ 2'b11;
    if (!hold_en) en = 1'b0;
    @(negedge clk25);
  endtask

  // Checks one whole frame cycle by cycle; at j==70 optionally changes pattern_sel and sets en.
  task automatic run_frame(input logic [1:0] pat, input logic [7:0] fc, input bit chg,
                           input logic [1:0] new_sel, input bit en_after);
    logic [15:0] sum;
    logic [15:0] pix;
    logic [7:0]  e_dout;
    logic [7:0]  e_fc;
    bit e_vs, e_href, e_fd;
    int line, h;
    sum = 16'h0000;
    for (int j = 0; j < FRAME; j++) begin
      e_vs   = (j < VS * HT);
      line   = (j - ACT0) / HT;
      h      = (j - ACT0) % HT;
      e_href = (j >= ACT0) && (j < ACT0 + H * HT) && (h < 2 * W);
      e_dout = 8'h00;
      if (e_href) begin
        pix    = model_pix(pat, h / 2, line, fc);
        e_dout = (h % 2 == 1) ? pix[7:0] : pix[15:8];
        sum    = sum + 16'(e_dout);
      end
      e_fd = (j == FRAME - 1);
      vectors++;
      if (vid.vsync !== e_vs) begin
        miscompares++;
        $display("FAIL vsync pat=%0d j=%0d got %b want %b", pat, j, vid.vsync, e_vs);
      end
      vectors++;
      if (vid.href !== e_href) begin
        miscompares++;
        $display("FAIL href pat=%0d j=%0d got %b want %b", pat, j, vid.href, e_href);
      end
      vectors++;
      if (vid.dout !== e_dout) begin
        miscompares++;
        $display("FAIL dout pat=%0d j=%0d got %h want %h", pat, j, vid.dout, e_dout);
      end
      vectors++;
      if (frame_done !== e_fd) begin
        miscompares++;
        $display("FAIL frame_done j=%0d got %b want %b", j, frame_done, e_fd);
      end
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_in_frame j=%0d got %b want 1", j, busy);
      end
      if (j == 0 || j == FRAME - 1) begin
        vectors++;
        if (frame_cnt !== fc) begin
          miscompares++;
          $display("FAIL frame_cnt_hold j=%0d got %0d want %0d", j, frame_cnt, fc);
        end
      end
      if (j == 70) begin
        if (chg) pattern_sel = new_sel;
        en = en_after;
      end
      @(negedge clk25);
    end
    e_fc = fc + 8'd1;
    vectors++;
    if (frame_cnt !== e_fc) begin
      miscompares++;
      $display("FAIL frame_cnt_inc got %0d want %0d", frame_cnt, e_fc);
    end
    vectors++;
    if (frame_sum !== (CKSUM ? sum : 16'h0000)) begin
      miscompares++;
      $display("FAIL frame_sum got %h want %h", frame_sum, CKSUM ? sum : 16'h0000);
    end
    vectors++;
    if (vid.vsync !== en_after || busy !== en_after) begin
      miscompares++;
      $display("FAIL frame_boundary vsync=%b busy=%b want %b %b", vid.vsync, busy, en_after, en_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    pattern_sel = 2'd0;
    repeat (2) @(negedge clk25);
    vectors++;
    if ({vid.vsync, vid.href, vid.dout, busy, frame_done, frame_cnt, frame_sum} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs vs=%b hr=%b d=%h busy=%b fd=%b fc=%h fs=%h want all 0",
               vid.vsync, vid.href, vid.dout, busy, frame_done, frame_cnt, frame_sum);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk25);
    vectors++;
    if (busy !== 1'b0 || vid.vsync !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_without_en busy=%b vsync=%b want 0 0", busy, vid.vsync);
    end
  endtask

  task automatic test_single_frame();
    start_frame(2'd0, 1'b0);
    run_frame(2'd0, 8'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame(2'd1, 1'b1);
    run_frame(2'd1, 8'd1, 1'b1, 2'd3, 1'b1);
    run_frame(2'd3, 8'd2, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_checker();
    start_frame(2'd2, 1'b0);
    run_frame(2'd2, 8'd3, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    start_frame(2'd0, 1'b0);
    repeat (50) @(negedge clk25);
    vectors++;
    if (vid.href !== 1'b1 || vid.dout !== 8'hF8) begin
      miscompares++;
      $display("FAIL pre_reset_active href=%b dout=%h want 1 f8", vid.href, vid.dout);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({vid.vsync, vid.href, vid.dout, busy, frame_done, frame_cnt} !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset vs=%b hr=%b d=%h busy=%b fd=%b fc=%h want all 0",
               vid.vsync, vid.href, vid.dout, busy, frame_done, frame_cnt);
    end
    #1 rst = 1'b0;
    repeat (6) @(negedge clk25);
    vectors++;
    if (busy !== 1'b0 || vid.vsync !== 1'b0 || frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle busy=%b vsync=%b fc=%0d want 0 0 0", busy, vid.vsync, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int done;
    bit prev;
    bit fin;
    done = 0;
    prev = 1'b0;
    fin  = 1'b0;
    pattern_sel = 2'd0;
    en = 1'b1;
    for (int c = 0; c < 300 * FRAME && !fin; c++) begin
      @(negedge clk25);
      if (prev) begin
        vectors++;
        if (frame_cnt !== 8'(done)) begin
          miscompares++;
          $display("FAIL wrap_count frames=%0d got %0d want %0d", done, frame_cnt, 8'(done));
        end
        if (done == 256) fin = 1'b1;
      end
      prev = frame_done;
      if (frame_done === 1'b1) begin
        done++;
        if (done == 255) en = 1'b0;
      end
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL wrap_timeout frames=%0d want 256", done);
    end
    @(negedge clk25);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_idle busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_checker();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
